// File: rtl/instruction_store_pkg.sv
// rtl/instruction_store_pkg.sv - shared widths and FSM encodings for the instruction store
package instruction_store_pkg;

    localparam int BYTE         = 8;
    localparam int WIDTH        = 4 * BYTE;
    localparam int ADDRESS_SIZE = 16;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] COMMIT = 1'b1;

endpackage

// File: rtl/instruction_ram.sv
// rtl/instruction_ram.sv - DEPTH x WIDTH array, one write port, registered read port with write-first bypass
module instruction_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             rd_in_range,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                end else if (we && (waddr == raddr)) begin
                    rd_data <= wdata;
                end else begin
                    rd_data <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: rtl/instruction_store.sv
// rtl/instruction_store.sv - commits decoder-issued instruction words into an on-chip array
module instruction_store
    import instruction_store_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [WIDTH-1:0]        instruction_in,
    output logic                    ready,
    output logic                    ack,
    output logic                    error,
    output logic                    overrun,
    input  logic                    rd_en,
    input  logic [ADDRESS_SIZE-1:0] rd_address,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [ADDRESS_SIZE-1:0] word_count
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDRESS_SIZE still compares correctly.
    localparam logic [ADDRESS_SIZE:0] DEPTH_EXT = (ADDRESS_SIZE + 1)'(DEPTH);

    logic [0:0]              state;
    logic [ADDRESS_SIZE-1:0] hold_address;
    logic [WIDTH-1:0]        hold_instruction;
    logic                    hold_in_range;
    logic                    rd_in_range;
    logic                    mem_we;

    assign ready         = (state == IDLE);
    assign hold_in_range = ({1'b0, hold_address} < DEPTH_EXT);
    assign rd_in_range   = ({1'b0, rd_address} < DEPTH_EXT);
    assign mem_we        = (state == COMMIT) && hold_in_range && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            hold_address     <= '0;
            hold_instruction <= '0;
            ack              <= 1'b0;
            error            <= 1'b0;
            overrun          <= 1'b0;
            word_count       <= '0;
        end else begin
            ack   <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hold_address     <= address;
                        hold_instruction <= instruction_in;
                        state            <= COMMIT;
                    end
                end
                default: begin
                    if (hold_in_range) begin
                        ack <= 1'b1;
                        if (word_count != '1) begin
                            word_count <= word_count + 1'b1;
                        end
                    end else begin
                        error <= 1'b1;
                    end
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

    instruction_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk         (clk),
        .reset       (reset),
        .we          (mem_we),
        .waddr       (hold_address[AW-1:0]),
        .wdata       (hold_instruction),
        .re          (rd_en),
        .rd_in_range (rd_in_range),
        .raddr       (rd_address[AW-1:0]),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

endmodule

// File: tb/tb_instruction_store.sv
// tb/tb_instruction_store.sv - directed self-checking bench for instruction_store
module tb_instruction_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] address;
    logic [31:0] instruction_in;
    logic        ready;
    logic        ack;
    logic        error;
    logic        overrun;
    logic        rd_en;
    logic [15:0] rd_address;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_store dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .address        (address),
        .instruction_in (instruction_in),
        .ready          (ready),
        .ack            (ack),
        .error          (error),
        .overrun        (overrun),
        .rd_en          (rd_en),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .word_count     (word_count)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; rd_en = 1'b0;
        address = '0; instruction_in = '0; rd_address = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Takes exactly two cycles; returns the ack/error seen in cycle N+2.
    task automatic write_word(input logic [15:0] a, input logic [31:0] d,
                              output logic got_ack, output logic got_err);
        start = 1'b1; address = a; instruction_in = d;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        got_ack = ack; got_err = error;
    endtask

    task automatic read_word(input logic [15:0] a, output logic [31:0] d, output logic v);
        rd_en = 1'b1; rd_address = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data; v = rd_valid;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    endtask

    task automatic test_single_write();
        logic [31:0] d; logic v;
        start = 1'b1; address = 16'h0003; instruction_in = 32'h920104E0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_n1 got %b want 0", ready); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_n1 got %b want 0", ack); end
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL single_ack_n2 got %b want 1", ack); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_n2 got %b want 1", ready); end
        checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL single_word_count got %0d want 1", word_count); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_n3 got %b want 0", ack); end
        read_word(16'h0003, d, v);
        checks++; if (d !== 32'h920104E0) begin errors++; $display("FAIL single_rd_data got %h want 920104e0", d); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %b want 1", v); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== 32'h920104E0) begin errors++; $display("FAIL hold_rd_data got %h want 920104e0", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic a_ok, e_ok; logic [31:0] d; logic v;
        int acks = 0; int bad_reads = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            write_word(16'(i), 32'hA5000000 + 32'(i * 32'h00010101), a_ok, e_ok);
            if (a_ok === 1'b1 && e_ok === 1'b0) acks++;
        end
        checks++; if (acks != 16) begin errors++; $display("FAIL fill_acks got %0d want 16", acks); end
        checks++; if (word_count !== 16'd16) begin errors++; $display("FAIL fill_word_count got %0d want 16", word_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_overrun got %b want 0", overrun); end
        for (int i = 0; i < 16; i++) begin
            read_word(16'(i), d, v);
            if (d !== 32'hA5000000 + 32'(i * 32'h00010101) || v !== 1'b1) bad_reads++;
        end
        checks++; if (bad_reads != 0) begin errors++; $display("FAIL fill_readback got %0d bad want 0", bad_reads); end
    endtask

    task automatic test_address_error();
        logic a_ok, e_ok; logic [31:0] d; logic v;
        write_word(16'h0010, 32'h11111111, a_ok, e_ok);
        checks++; if (e_ok !== 1'b1) begin errors++; $display("FAIL err16_error got %b want 1", e_ok); end
        checks++; if (a_ok !== 1'b0) begin errors++; $display("FAIL err16_ack got %b want 0", a_ok); end
        checks++; if (word_count !== 16'd16) begin errors++; $display("FAIL err16_word_count got %0d want 16", word_count); end
        @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err16_pulse_end got %b want 0", error); end
        read_word(16'h0000, d, v);
        checks++; if (d !== 32'hA5000000) begin errors++; $display("FAIL err16_addr0_intact got %h want a5000000", d); end
        write_word(16'h8003, 32'h22222222, a_ok, e_ok);
        checks++; if (e_ok !== 1'b1 || a_ok !== 1'b0) begin errors++; $display("FAIL err8003_flags got ack=%b err=%b want ack=0 err=1", a_ok, e_ok); end
        read_word(16'h0003, d, v);
        checks++; if (d !== 32'hA5030303) begin errors++; $display("FAIL err8003_alias_intact got %h want a5030303", d); end
        read_word(16'h0010, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL oor_read got data=%h valid=%b want 0/1", d, v); end
    endtask

    task automatic test_overrun();
        logic a_ok, e_ok; logic [31:0] d; logic v;
        start = 1'b1; address = 16'h0007; instruction_in = 32'hCAFE0007;
        @(negedge clk);
        address = 16'h0008; instruction_in = 32'hBAD00008;
        @(negedge clk);
        start = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovr_first_ack got %b want 1", ack); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        checks++; if (word_count !== 16'd17) begin errors++; $display("FAIL ovr_word_count got %0d want 17", word_count); end
        @(negedge clk);
        read_word(16'h0007, d, v);
        checks++; if (d !== 32'hCAFE0007) begin errors++; $display("FAIL ovr_rd7 got %h want cafe0007", d); end
        read_word(16'h0008, d, v);
        checks++; if (d !== 32'hA5080808) begin errors++; $display("FAIL ovr_rd8_dropped got %h want a5080808", d); end
        write_word(16'h0001, 32'h01010101, a_ok, e_ok);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_collision();
        start = 1'b1; address = 16'h0005; instruction_in = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; rd_en = 1'b1; rd_address = 16'h0005;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd_data got %h want deadbeef", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bypass_rd_valid got %b want 1", rd_valid); end
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bypass_ack got %b want 1", ack); end
    endtask

    task automatic test_reset_mid_commit();
        logic a_ok, e_ok; logic [31:0] d; logic v;
        write_word(16'h0009, 32'h99990001, a_ok, e_ok);
        start = 1'b1; address = 16'h0009; instruction_in = 32'h99990002;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b want 0", ack); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL midrst_word_count got %0d want 0", word_count); end
        checks++; if (overrun !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL midrst_flags got overrun=%b ready=%b want 0/1", overrun, ready); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_late_ack got %b want 0", ack); end
        read_word(16'h0009, d, v);
        checks++; if (d !== 32'h99990001) begin errors++; $display("FAIL midrst_word9 got %h want 99990001", d); end
        start = 1'b1; reset = 1'b1; address = 16'h0002; instruction_in = 32'h77777777;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_start_ready got %b want 1", ready); end
        @(negedge clk);
        checks++; if (ack !== 1'b0 || word_count !== 16'd0) begin errors++; $display("FAIL rst_start_no_commit got ack=%b count=%0d want 0/0", ack, word_count); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rd_en = 1'b0;
        address = '0; instruction_in = '0; rd_address = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_address_error();
        test_overrun();
        test_collision();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
